// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit active-low 7-segment scan driver with inter-digit blanking and
// frame-coherent shadow capture. Define SEG7_DIM_EN to add the iBrightness PWM dimmer.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic [7:0] iChar1,
  input  logic [7:0] iChar2,
  input  logic [7:0] iChar3,
  input  logic [7:0] iChar4,
`ifdef SEG7_DIM_EN
  input  logic [3:0] iBrightness,
`endif
  output logic [7:0] oSeg,
  output logic [3:0] oAnode,
  output logic       oFrameStart
);

  localparam int            CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            first_q;
  logic [3:0][7:0] shadow_q;
  logic [7:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            fs_q;
  logic            tc, load, blank, dim_ok, lit;

  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign blank = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
      assign blank = (cnt_q < BLANK_C);
    end
  endgenerate

`ifdef SEG7_DIM_EN
  logic [3:0] pwm_q;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) pwm_q <= 4'd0;
    else           pwm_q <= pwm_q + 4'd1;
  end

  // Brightness is used live, not shadowed; pwm <= level gives (level+1)/16 duty.
  assign dim_ok = (pwm_q <= iBrightness);
`else
  assign dim_ok = 1'b1;
`endif

  always_comb begin
    tc    = (cnt_q == TC);
    cnt_d = tc ? '0 : cnt_q + CW'(1);
    idx_d = tc ? idx_q + 2'd1 : idx_q;
    // first_q forces a load on the first edge after reset so the display never starts stale
    load  = first_q | (tc & (idx_q == 2'd3));
    lit   = ~blank & dim_ok;
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (lit) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = shadow_q[idx_q];
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      first_q  <= 1'b1;
      shadow_q <= {4{8'hFF}};
      seg_q    <= 8'hFF;
      an_q     <= 4'hF;
      fs_q     <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      first_q <= 1'b0;
      if (load) shadow_q <= {iChar4, iChar3, iChar2, iChar1};
      seg_q   <= seg_d;
      an_q    <= an_d;
      fs_q    <= load;
    end
  end

  assign oSeg        = seg_q;
  assign oAnode      = an_q;
  assign oFrameStart = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (8/2 with blanking, 4/0 without) checked
// against a time-indexed reference model, plus a vector table and reset/coherence sequences.
module tb_seg7_scan_driver;

  localparam int SD_A = 8, BL_A = 2;
  localparam int SD_B = 4, BL_B = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] c1 = 8'hFF, c2 = 8'hFF, c3 = 8'hFF, c4 = 8'hFF;
  logic [3:0] bright = 4'hF;
  logic [7:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       fs_a, fs_b;

  int compared = 0;
  int mismatched = 0;

  // state count since reset release (edges taken while running)
  int              t = 0;
  logic [3:0][7:0] sh_a = {4{8'hFF}};
  logic [3:0][7:0] sh_b = {4{8'hFF}};
  logic [3:0]      ean_a, ean_b;
  logic [7:0]      eseg_a, eseg_b;
  logic            efs_a, efs_b;

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(SD_A), .BLANK_CYCLES(BL_A)) dut_a (
    .iClk(clk), .iReset_n(rst_n),
    .iChar1(c1), .iChar2(c2), .iChar3(c3), .iChar4(c4),
`ifdef SEG7_DIM_EN
    .iBrightness(bright),
`endif
    .oSeg(seg_a), .oAnode(an_a), .oFrameStart(fs_a)
  );

  seg7_scan_driver #(.SCAN_DIV(SD_B), .BLANK_CYCLES(BL_B)) dut_b (
    .iClk(clk), .iReset_n(rst_n),
    .iChar1(c1), .iChar2(c2), .iChar3(c3), .iChar4(c4),
`ifdef SEG7_DIM_EN
    .iBrightness(bright),
`endif
    .oSeg(seg_b), .oAnode(an_b), .oFrameStart(fs_b)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s at t=%0d: got %h, expected %h", name, t, act, req);
    end
  endtask

  // Display content for state tt: slot position, digit, and whether the digit is lit.
  function automatic void model(input int sd, input int bl, input int tt,
                                input logic [3:0][7:0] sh,
                                output logic [3:0] an, output logic [7:0] seg,
                                output logic fs);
    int  pos, dig;
    bit  on;
    pos = tt % sd;
    dig = (tt / sd) % 4;
    on  = (pos >= bl);
`ifdef SEG7_DIM_EN
    on  = on && ((tt % 16) <= int'(bright));
`endif
    an  = 4'hF;
    seg = 8'hFF;
    if (on) begin
      an[dig] = 1'b0;
      seg     = sh[dig];
    end
    fs = (tt == 0) || (tt % (4 * sd) == 4 * sd - 1);
  endfunction

  task automatic model_reset();
    t    = 0;
    sh_a = {4{8'hFF}};
    sh_b = {4{8'hFF}};
  endtask

  // One clock: predict from the pre-edge state, then compare both instances 1ns later.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model(SD_A, BL_A, t, sh_a, ean_a, eseg_a, efs_a);
      model(SD_B, BL_B, t, sh_b, ean_b, eseg_b, efs_b);
      if (efs_a) sh_a = {c4, c3, c2, c1};
      if (efs_b) sh_b = {c4, c3, c2, c1};
      t++;
    end else begin
      ean_a = 4'hF; eseg_a = 8'hFF; efs_a = 1'b0;
      ean_b = 4'hF; eseg_b = 8'hFF; efs_b = 1'b0;
    end
    #1;
    check("a_anode", {4'h0, an_a}, {4'h0, ean_a});
    check("a_seg",   seg_a, eseg_a);
    check("a_frame", {7'h0, fs_a}, {7'h0, efs_a});
    check("b_anode", {4'h0, an_b}, {4'h0, ean_b});
    check("b_seg",   seg_b, eseg_b);
    check("b_frame", {7'h0, fs_b}, {7'h0, efs_b});
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] chars;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        fs;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1,  32'hF8B0B0F9, 4'hF, 8'hFF, 1'b1};
    tbl[1]  = '{2,  32'hF8B0B0F9, 4'hF, 8'hFF, 1'b0};
    tbl[2]  = '{3,  32'hF8B0B0F9, 4'hE, 8'hF9, 1'b0};
    tbl[3]  = '{8,  32'hF8B0B0F9, 4'hE, 8'hF9, 1'b0};
    tbl[4]  = '{9,  32'hF8B0B0F9, 4'hF, 8'hFF, 1'b0};
    tbl[5]  = '{11, 32'hF8B0B0F9, 4'hD, 8'hB0, 1'b0};
    tbl[6]  = '{19, 32'hF8B0B0F9, 4'hB, 8'hB0, 1'b0};
    tbl[7]  = '{27, 32'hF8B0B0F9, 4'h7, 8'hF8, 1'b0};
    tbl[8]  = '{32, 32'hF8B0B0F9, 4'h7, 8'hF8, 1'b1};
    tbl[9]  = '{33, 32'hF8B0B0F9, 4'hF, 8'hFF, 1'b0};
    tbl[10] = '{35, 32'hF8B0B0F9, 4'hE, 8'hF9, 1'b0};
    tbl[11] = '{64, 32'hF8B0B0F9, 4'h7, 8'hF8, 1'b1};

    #2 rst_n = 1'b0;

    // Reset hold: inputs toggle, outputs must stay idle.
    for (int i = 0; i < 6; i++) begin
      step();
      {c4, c3, c2, c1} = $urandom;
    end

    // Basic scan from the vector table on the 8/2 instance.
    bright = 4'hF;
    {c4, c3, c2, c1} = tbl[0].chars;
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      {c4, c3, c2, c1} = tbl[i].chars;
      run_to(tbl[i].cyc);
      check("tbl_anode", {4'h0, an_a}, {4'h0, tbl[i].an});
      check("tbl_seg",   seg_a, tbl[i].seg);
      check("tbl_frame", {7'h0, fs_a}, {7'h0, tbl[i].fs});
    end

    // Randomized characters (and brightness when dimming is built in).
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: c1 = 8'($urandom);
          1: c2 = 8'($urandom);
          2: c3 = 8'($urandom);
          default: c4 = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 31) == 0) bright = 4'($urandom);
      step();
    end

    // Asynchronous reset during digit 2 active window of the 8/2 instance.
    bright = 4'hF;
    run_to(t + (4 * SD_A - t % (4 * SD_A)) + 2 * SD_A + 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_anode_a", {4'h0, an_a}, 8'h0F);
    check("async_seg_a",   seg_a, 8'hFF);
    check("async_frame_a", {7'h0, fs_a}, 8'h00);
    check("async_anode_b", {4'h0, an_b}, 8'h0F);
    check("async_seg_b",   seg_b, 8'hFF);
    step();
    step();

    // Restart with fresh load, then frame coherence: change char 1 mid-frame.
    {c4, c3, c2, c1} = 32'hF8B0B0F9;
    model_reset();
    rst_n = 1'b1;
    run_to(1);
    check("restart_frame", {7'h0, fs_a}, 8'h01);
    check("restart_anode", {4'h0, an_a}, 8'h0F);
    run_to(3);
    check("restart_digit0", seg_a, 8'hF9);
    run_to(17);
    c1 = 8'h92;
    run_to(32);
    check("coh_frame", {7'h0, fs_a}, 8'h01);
    check("coh_old_d3", seg_a, 8'hF8);
    run_to(35);
    check("coh_new_anode", {4'h0, an_a}, 8'h0E);
    check("coh_new_d0", seg_a, 8'h92);
    run_to(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Multiplexed 4-digit 7-segment display driver. Sits directly downstream of the text/character selection stage.
- Consumes four active-low segment bytes and time-multiplexes them onto one shared segment bus plus four active-low digit anodes.
- Adds anti-ghosting blanking between digits and frame-coherent capture, so a digit never shows a half-updated message.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot; must be at least 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must be less than SCAN_DIV, and 0 disables blanking.

Ports:
- iClk  input  1  system clock.
- iReset_n  input  1  asynchronous active-low reset.
- iChar1  input  8  digit 0 (leftmost) segment byte, active-low; bit0=a..bit6=g, bit7=dp.
- iChar2  input  8  digit 1 segment byte.
- iChar3  input  8  digit 2 segment byte.
- iChar4  input  8  digit 3 (rightmost) segment byte.
- oSeg  output  8  shared segment bus, active-low, same bit order as the inputs.
- oAnode  output  4  digit enables, active-low; oAnode[k] drives digit k.
- oFrameStart  output  1  one-cycle pulse when the shadow characters are reloaded.
- iBrightness  input  4  brightness level; present only when SEG7_DIM_EN is defined.

Behaviour:
- Clock/reset: single clock domain iClk; asynchronous active-low reset iReset_n.
- Reset state: slot counter=0, digit index=0, shadow chars=8'hFF, oSeg=8'hFF, oAnode=4'hF, oFrameStart=0. Reset applies immediately on assertion, including mid-slot or mid-frame.
- Slot counter: counts 0..SCAN_DIV-1 and wraps. At terminal count the digit index advances 0->1->2->3->0.
- Counter width: $clog2(SCAN_DIV).
- Shadow load occurs:
  - on the first rising edge after reset release;
  - when the slot counter is at terminal count and the digit index is 3 (frame wrap).
- Shadow load actions: all four iCharN are captured together. oFrameStart=1 on the cycle after the load edge, and 0 otherwise.
- Input changes between loads are invisible on the display.
- Output latency: oSeg, oAnode and oFrameStart are registered and reflect the counter/index state one clock earlier.
- Blank window: if counter < BLANK_CYCLES, then oAnode=4'hF and oSeg=8'hFF.
- Active window: otherwise oAnode has only bit[index] low, and oSeg = shadow[index].
- Frame period: 4*SCAN_DIV cycles. Slot order is fixed: digit 0 -> 1 -> 2 -> 3.
- BLANK_CYCLES=0: no gap; the anode moves directly from one digit to the next and the segment bus changes on the same edge.
- Input constraint: iCharN is assumed synchronous to iClk; no internal synchronisers.

Optional Feature:
- Macro: SEG7_DIM_EN.
- When defined:
  - Port iBrightness[3:0] exists, plus a free-running 4-bit PWM counter that resets to 0.
  - During the active window, the anode is low only when pwm <= iBrightness; otherwise oAnode=4'hF and oSeg=8'hFF.
  - iBrightness=15 gives a 16/16 duty; iBrightness=0 gives 1/16.
  - iBrightness is sampled every cycle and is not shadowed.
- When undefined: no port and no PWM counter; behaviour is identical to iBrightness=15.

Test Plan:
- Reset hold: SCAN_DIV=8, BLANK_CYCLES=2, iReset_n=0, toggle iChar1..4 -> oAnode=4'hF, oSeg=8'hFF, oFrameStart=0 throughout.
- Basic scan: release reset with iChar=F9,B0,B0,F8 -> oFrameStart pulses once. Each 8-cycle slot shows 2 blank cycles (F/FF), then 6 cycles of E/F9, D/B0, B/B0, 7/F8. Pattern repeats every 32 cycles, with oFrameStart once per frame.
- Frame coherence: during digit 2 of a frame, change iChar1 to 92 -> digit 0 still shows F9 for the rest of that frame. After the next oFrameStart it shows 92.
- Reset mid-operation: assert iReset_n=0 during digit 2 active window -> outputs go to F/FF asynchronously without waiting for a clock. After release, the scan restarts at digit 0 with a fresh load and an oFrameStart pulse.
- No blanking: BLANK_CYCLES=0, SCAN_DIV=4 -> no F/FF cycles after the first load. The anode sequence E,D,B,7 holds for 4 cycles each.
- Dimming (SEG7_DIM_EN): SCAN_DIV=64, BLANK_CYCLES=0, iBrightness=3 -> 16 anode-low cycles per 64-cycle slot, in runs of 4 per 16 cycles. iBrightness=15 -> 64 anode-low cycles per slot.
